axi4lite_reg_bank_50: RTL and testbench

- AXI4-Lite slave register bank with 50 × 32-bit registers; the responder end of the AXI VIP master used in the 50-register IP example design.
- Registers 0..NUM_WR-1 are read/write control registers, presented to the fabric as one flat bus with per-register write strobes.
- Registers NUM_WR..NUM_REGS-1 are read-only and mirror fabric status inputs.
- Illegal accesses return SLVERR.

---
 rtl/axi4lite_reg_bank_50.sv | 194 +++++++++++++++++++
 tb/tb_axi4lite_reg_bank_50.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_bank_50.sv
// AXI4-Lite slave register bank: NUM_WR byte-strobed control registers driven
// onto a flat fabric bus, followed by read-only status mirrors.

module axi4lite_reg_bank_50_cell (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (we)
      for (int b = 0; b < 4; b++)
        if (strb[b]) q[8*b +: 8] <= d[8*b +: 8];
  end
endmodule

module axi4lite_reg_bank_50 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS           = 50,
  parameter int NUM_WR             = 40
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_WR-1:0]            ctrl_regs,
  output logic [NUM_WR-1:0]               ctrl_wr_pulse,
  input  logic [32*(NUM_REGS-NUM_WR)-1:0] status_regs
);
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_RO = NUM_REGS - NUM_WR;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_RESP} rst_t;

  wst_t w_q, w_d;
  rst_t r_q, r_d;
  logic rdy_en;
  logic aw_hs, w_hs, ar_hs, commit, c_ok;
  logic [IDX_W-1:0] aw_idx_q, c_idx;
  logic [31:0] wdata_q, c_data, c_idx32, r_idx32, rd_data;
  logic [3:0]  wstrb_q, c_strb;
  logic [1:0]  rd_resp;
  logic [NUM_WR-1:0] we_vec;
  logic [NUM_WR-1:0][31:0] regs;
  logic [NUM_RO-1:0][31:0] st;
  logic unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign st        = status_regs;
  assign ctrl_regs = regs;

  // Readies are held low through reset and for the release edge itself.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rdy_en <= 1'b0;
    else                rdy_en <= 1'b1;
  end

  assign S_AXI_AWREADY = rdy_en && (w_q == W_IDLE || w_q == W_HAVE_D);
  assign S_AXI_WREADY  = rdy_en && (w_q == W_IDLE || w_q == W_HAVE_A);
  assign S_AXI_ARREADY = rdy_en && (r_q == R_IDLE);
  assign S_AXI_BVALID  = (w_q == W_RESP);
  assign S_AXI_RVALID  = (r_q == R_RESP);
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit operands come from the live bus for whichever half arrives last.
  always_comb begin
    w_d    = w_q;
    commit = 1'b0;
    c_idx  = aw_idx_q;
    c_data = wdata_q;
    c_strb = wstrb_q;
    case (w_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
          w_d    = W_RESP;
        end else if (aw_hs) w_d = W_HAVE_A;
        else if (w_hs)      w_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs) begin
        commit = 1'b1;
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
        w_d    = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        commit = 1'b1;
        c_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_d    = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  assign c_idx32 = 32'(c_idx);
  assign c_ok    = c_idx32 < NUM_WR;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_reg
    assign we_vec[g] = commit && (c_idx32 == g);
    axi4lite_reg_bank_50_cell u_cell (
      .clk  (S_AXI_ACLK),
      .rst_n(S_AXI_ARESETN),
      .we   (we_vec[g]),
      .strb (c_strb),
      .d    (c_data),
      .q    (regs[g])
    );
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_q           <= W_IDLE;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_BRESP   <= 2'b00;
      ctrl_wr_pulse <= '0;
    end else begin
      w_q           <= w_d;
      ctrl_wr_pulse <= we_vec;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) S_AXI_BRESP <= c_ok ? 2'b00 : 2'b10;
    end
  end

  // Read mux sees pre-commit register values, so a same-edge write is not forwarded.
  assign r_idx32 = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  always_comb begin
    rd_data = '0;
    rd_resp = 2'b10;
    if (r_idx32 < NUM_WR) begin
      rd_resp = 2'b00;
      for (int i = 0; i < NUM_WR; i++) if (r_idx32 == i) rd_data = regs[i];
    end else if (r_idx32 < NUM_REGS) begin
      rd_resp = 2'b00;
      for (int i = 0; i < NUM_RO; i++) if (r_idx32 == NUM_WR + i) rd_data = st[i];
    end
  end

  always_comb begin
    r_d = r_q;
    case (r_q)
      R_IDLE:  if (ar_hs) r_d = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_q         <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      r_q <= r_d;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_data;
        S_AXI_RRESP <= rd_resp;
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_reg_bank_50.sv
// Randomized self-checking bench for axi4lite_reg_bank_50 with an array-based register model.

module tb_axi4lite_reg_bank_50;
  localparam int NR = 50, NW = 40, NRO = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [32*NW-1:0]  ctrl_regs;
  logic [NW-1:0]     ctrl_wr_pulse;
  logic [32*NRO-1:0] status_regs;

  logic [31:0] mdl [NW];
  logic [31:0] st_m [NRO];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    status_regs = '0;
    for (int i = 0; i < NRO; i++) status_regs[32*i +: 32] = st_m[i];
  end

  axi4lite_reg_bank_50 dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_regs(status_regs)
  );

  // ---------------- reference model ----------------
  function automatic void mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < NW)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endfunction
  function automatic logic [31:0] mdl_rdata(input int idx);
    if (idx < NW) return mdl[idx];
    if (idx < NR) return st_m[idx-NW];
    return 32'h0;
  endfunction
  function automatic logic [1:0] mdl_bresp(input int idx);
    return (idx < NW) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [1:0] mdl_rresp(input int idx);
    return (idx < NR) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [NW-1:0] mdl_pulse(input int idx);
    logic [NW-1:0] p = '0;
    if (idx < NW) p[idx] = 1'b1;
    return p;
  endfunction
  function automatic logic [32*NW-1:0] mdl_flat();
    logic [32*NW-1:0] f;
    for (int i = 0; i < NW; i++) f[32*i +: 32] = mdl[i];
    return f;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output logic [NW-1:0] pls,
                          output logic [NW-1:0] pls_next, output logic b_imm, output logic ok);
    bit aw_done = 0, w_done = 0, awf, wf;
    int t = 0;
    ok = 1'b1;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      awf = awvalid && awready;
      wf  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= awf; w_done |= wf;
      t++;
      if (t > 40) begin ok = 1'b0; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    b_imm = bvalid;
    t = 0;
    while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp; pls = ctrl_wr_pulse;
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    pls_next = ctrl_wr_pulse;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic ok);
    bit f = 0;
    int t = 0;
    ok = 1'b1;
    araddr = a;
    while (!f) begin
      arvalid = 1'b1;
      f = arready;
      @(posedge clk); #1;
      t++;
      if (t > 40) begin ok = 1'b0; break; end
    end
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(posedge clk); #1; t++; end
    if (!rvalid) ok = 1'b0;
    d = rdata; resp = rresp;
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin bad++;
      $display("FAIL reset_hs got=%b exp=00000", {awready, wready, arready, bvalid, rvalid}); end
    total++; if ({bresp, rresp, rdata} !== 36'h0) begin bad++;
      $display("FAIL reset_resp got=%h exp=0", {bresp, rresp, rdata}); end
    total++; if (ctrl_regs !== '0 || ctrl_wr_pulse !== '0) begin bad++;
      $display("FAIL reset_regs got=%h pulse=%h exp=0", ctrl_regs, ctrl_wr_pulse); end
    rst_n = 1'b1; #1;
    total++; if ({awready, wready, arready} !== 3'b000) begin bad++;
      $display("FAIL release_before_edge got=%b exp=000", {awready, wready, arready}); end
    @(posedge clk); #1;
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++;
      $display("FAIL release_ready got=%b exp=111", {awready, wready, arready}); end
  endtask

  task automatic test_seq_write();
    logic [1:0] r; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      do_write(8'(4*i), 32'(i+1), 4'hF, 0, 0, r, p, pn, bi, ok);
      mdl_write(i, 32'(i+1), 4'hF);
      total++; if (!ok || r !== 2'b00) begin bad++;
        $display("FAIL seq_bresp[%0d] got=%b ok=%b exp=00", i, r, ok); end
      total++; if (p !== mdl_pulse(i) || pn !== '0) begin bad++;
        $display("FAIL seq_pulse[%0d] got=%h next=%h exp=%h", i, p, pn, mdl_pulse(i)); end
    end
    total++; if (ctrl_regs !== mdl_flat()) begin bad++;
      $display("FAIL seq_ctrl got=%h exp=%h", ctrl_regs[127:0], mdl_flat()); end
    for (int i = 0; i < 4; i++) begin
      do_read(8'(4*i), d, r, ok);
      total++; if (!ok || d !== mdl_rdata(i) || r !== 2'b00) begin bad++;
        $display("FAIL seq_read[%0d] got=%h/%b exp=%h/00", i, d, r, mdl_rdata(i)); end
    end
  endtask

  task automatic test_order();
    logic [1:0] r; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    do_write(8'h10, 32'hDEADBEEF, 4'hF, 3, 0, r, p, pn, bi, ok);
    mdl_write(4, 32'hDEADBEEF, 4'hF);
    total++; if (!ok || bi !== 1'b1 || r !== 2'b00) begin bad++;
      $display("FAIL order_w_first bvalid_next=%b resp=%b ok=%b exp=1/00", bi, r, ok); end
    do_write(8'h14, 32'hDEADBEEF, 4'hF, 0, 3, r, p, pn, bi, ok);
    mdl_write(5, 32'hDEADBEEF, 4'hF);
    total++; if (!ok || bi !== 1'b1 || p !== mdl_pulse(5)) begin bad++;
      $display("FAIL order_aw_first bvalid_next=%b pulse=%h ok=%b exp=1", bi, p, ok); end
    for (int i = 4; i < 6; i++) begin
      do_read(8'(4*i), d, r, ok);
      total++; if (!ok || d !== 32'hDEADBEEF) begin bad++;
        $display("FAIL order_read[%0d] got=%h exp=deadbeef", i, d); end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    do_write(8'h14, 32'h11223344, 4'hF, 0, 0, r, p, pn, bi, ok);
    mdl_write(5, 32'h11223344, 4'hF);
    do_write(8'h14, 32'hAABBCCDD, 4'b0101, 0, 0, r, p, pn, bi, ok);
    mdl_write(5, 32'hAABBCCDD, 4'b0101);
    do_read(8'h14, d, r, ok);
    total++; if (!ok || d !== 32'h11BB33DD || d !== mdl_rdata(5)) begin bad++;
      $display("FAIL strobe got=%h exp=11bb33dd", d); end
    do_write(8'h14, 32'hFFFFFFFF, 4'b0000, 0, 0, r, p, pn, bi, ok);
    total++; if (p !== mdl_pulse(5) || ctrl_regs !== mdl_flat()) begin bad++;
      $display("FAIL strobe_zero pulse=%h exp=%h", p, mdl_pulse(5)); end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    do_write(8'hA0, 32'h1234, 4'hF, 0, 0, r, p, pn, bi, ok);
    total++; if (!ok || r !== 2'b10 || p !== '0) begin bad++;
      $display("FAIL err_ro_write resp=%b pulse=%h exp=10/0", r, p); end
    total++; if (ctrl_regs !== mdl_flat()) begin bad++;
      $display("FAIL err_ro_unchanged got=%h", ctrl_regs[191:0]); end
    do_read(8'hC8, d, r, ok);
    total++; if (!ok || d !== 32'h0 || r !== 2'b10) begin bad++;
      $display("FAIL err_oor_read got=%h/%b exp=0/10", d, r); end
    st_m[0] = 32'hCAFE0001;
    do_read(8'hA0, d, r, ok);
    total++; if (!ok || d !== 32'hCAFE0001 || r !== 2'b00) begin bad++;
      $display("FAIL status_read got=%h/%b exp=cafe0001/00", d, r); end
    do_read(8'hFF, d, r, ok);
    total++; if (!ok || d !== 32'h0 || r !== 2'b10) begin bad++;
      $display("FAIL err_top_read got=%h/%b exp=0/10", d, r); end
  endtask

  task automatic test_backpressure();
    logic [1:0] b0; logic [31:0] rexp, wd;
    wd = $urandom;
    st_m[5] = $urandom;
    rexp = st_m[5];
    awaddr = 8'h04; wdata = wd; wstrb = 4'hF; araddr = 8'hB4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mdl_write(1, wd, 4'hF);
    b0 = bresp;
    st_m[5] = ~rexp;
    for (int c = 0; c < 10; c++) begin
      total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000 ||
                   bresp !== 2'b00 || b0 !== 2'b00 || rdata !== rexp || rresp !== 2'b00) begin bad++;
        $display("FAIL stall[%0d] hs=%b bresp=%b rdata=%h exp=11000/00/%h",
                 c, {bvalid, rvalid, awready, wready, arready}, bresp, rdata, rexp); end
      @(posedge clk); #1;
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin bad++;
      $display("FAIL stall_release got=%b exp=00111", {bvalid, rvalid, awready, wready, arready}); end
    total++; if (ctrl_regs !== mdl_flat()) begin bad++;
      $display("FAIL stall_write got=%h exp=%h", ctrl_regs[63:32], mdl[1]); end
  endtask

  task automatic test_same_edge();
    logic [1:0] r; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    do_write(8'h08, 32'h3, 4'hF, 0, 0, r, p, pn, bi, ok);
    mdl_write(2, 32'h3, 4'hF);
    awaddr = 8'h08; wdata = 32'h55; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    total++; if (!rvalid || rdata !== 32'h3 || !bvalid) begin bad++;
      $display("FAIL same_edge got=%h rv=%b bv=%b exp=00000003", rdata, rvalid, bvalid); end
    mdl_write(2, 32'h55, 4'hF);
    bready = 1'b1; rready = 1'b1; @(posedge clk); #1; bready = 1'b0; rready = 1'b0;
    do_read(8'h08, d, r, ok);
    total++; if (!ok || d !== 32'h55) begin bad++;
      $display("FAIL same_edge_after got=%h exp=00000055", d); end
  endtask

  task automatic test_random();
    logic [1:0] r, lo; logic [NW-1:0] p, pn; logic bi, ok; logic [31:0] d;
    logic [5:0] idx; logic [3:0] s;
    for (int n = 0; n < 60; n++) begin
      idx = 6'($urandom_range(0, 63)); lo = 2'($urandom);
      if ($urandom_range(0, 3) == 0) st_m[$urandom_range(0, NRO-1)] = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom);
        do_write({idx, lo}, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p, pn, bi, ok);
        mdl_write(int'(idx), d, s);
        total++; if (!ok || r !== mdl_bresp(int'(idx)) || p !== mdl_pulse(int'(idx)) ||
                     pn !== '0 || ctrl_regs !== mdl_flat()) begin bad++;
          $display("FAIL rnd_write[%0d] idx=%0d resp=%b exp=%b pulse=%h exp=%h",
                   n, idx, r, mdl_bresp(int'(idx)), p, mdl_pulse(int'(idx))); end
      end else begin
        do_read({idx, lo}, d, r, ok);
        total++; if (!ok || d !== mdl_rdata(int'(idx)) || r !== mdl_rresp(int'(idx))) begin bad++;
          $display("FAIL rnd_read[%0d] idx=%0d got=%h/%b exp=%h/%b",
                   n, idx, d, r, mdl_rdata(int'(idx)), mdl_rresp(int'(idx))); end
      end
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 8'h08; awvalid = 1'b1;
    total++; if (awready !== 1'b1) begin bad++;
      $display("FAIL mid_aw_ready got=%b exp=1", awready); end
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst_n = 1'b0; #1;
    total++; if ({awready, wready, arready} !== 3'b000 || ctrl_regs !== '0) begin bad++;
      $display("FAIL mid_reset_assert rdy=%b exp=000", {awready, wready, arready}); end
    for (int i = 0; i < NW; i++) mdl[i] = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++;
      $display("FAIL mid_ready_back got=%b exp=111", {awready, wready, arready}); end
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++; if (bvalid !== 1'b0 || ctrl_wr_pulse !== '0 || ctrl_regs !== mdl_flat()) begin bad++;
        $display("FAIL mid_no_commit[%0d] bvalid=%b pulse=%h exp=0", c, bvalid, ctrl_wr_pulse); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mdl[i] = '0;
    for (int i = 0; i < NRO; i++) st_m[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_seq_write();
    test_order();
    test_strobe();
    test_errors();
    test_backpressure();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
